truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer_if.sv | 25 ++
 rtl/truth_table_sequencer.sv | 129 ++++++++++++
 tb/tb_truth_table_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/truth_table_sequencer_if.sv
// Handshake and result bus between the truth-table sequencer and its consumer.
// The master side issues start/row_ready; the sequencer (slave) returns rows and tables.
interface truth_table_sequencer_if;
  logic       start;
  logic       row_ready;
  logic       busy;
  logic       row_valid;
  logic       row_x;
  logic       row_y;
  logic       row_fa;
  logic       row_fb;
  logic [3:0] table_a;
  logic [3:0] table_b;
  logic       done;

  modport master (
    output start, row_ready,
    input  busy, row_valid, row_x, row_y, row_fa, row_fb, table_a, table_b, done
  );

  modport slave (
    input  start, row_ready,
    output busy, row_valid, row_x, row_y, row_fa, row_fb, table_a, table_b, done
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all four {x,y} vectors through two gate functions, holding each vector
// STEP_DELAY cycles before sampling, and hands each row out over a valid/ready handshake.
module truth_table_sequencer_fa (
  input  logic i_x,
  input  logic i_y,
  output logic o_f
);
  assign o_f = ~i_x & i_y;
endmodule

module truth_table_sequencer_fb (
  input  logic i_x,
  input  logic i_y,
  output logic o_f
);
  assign o_f = ~i_x | ~i_y;
endmodule

module truth_table_sequencer #(
  parameter int STEP_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAST_CNT = 4'(STEP_DELAY - 1);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_row_valid;
  logic       r_row_fa;
  logic       r_row_fb;
  logic [3:0] r_table_a;
  logic [3:0] r_table_b;
  logic       r_done;

  logic w_x;
  logic w_y;
  logic w_fa;
  logic w_fb;

  // The gates see the registered vector index directly, so x/y only move on a clock edge.
  assign w_x = r_idx[1];
  assign w_y = r_idx[0];

  truth_table_sequencer_fa u_fa (.i_x(w_x), .i_y(w_y), .o_f(w_fa));
  truth_table_sequencer_fb u_fb (.i_x(w_x), .i_y(w_y), .o_f(w_fb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_row_valid <= 1'b0;
      r_row_fa    <= 1'b0;
      r_row_fb    <= 1'b0;
      r_table_a   <= 4'd0;
      r_table_b   <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= SETTLE;
            r_idx     <= 2'd0;
            r_cnt     <= 4'd0;
            r_table_a <= 4'd0;
            r_table_b <= 4'd0;
            r_busy    <= 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == LP_LAST_CNT) begin
            r_row_fa         <= w_fa;
            r_row_fb         <= w_fb;
            r_table_a[r_idx] <= w_fa;
            r_table_b[r_idx] <= w_fb;
            r_row_valid      <= 1'b1;
            r_state          <= HOLD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (bus.row_ready) begin
            r_row_valid <= 1'b0;
            // Index stops at 3 on the last row; it is only re-zeroed by the next start.
            if (r_idx != 2'd3) begin
              r_idx   <= r_idx + 2'd1;
              r_cnt   <= 4'd0;
              r_state <= SETTLE;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.row_valid = r_row_valid;
  assign bus.row_x     = w_x;
  assign bus.row_y     = w_y;
  assign bus.row_fa    = r_row_fa;
  assign bus.row_fb    = r_row_fb;
  assign bus.table_a   = r_table_a;
  assign bus.table_b   = r_table_b;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: expected rows are queued at each start and checked as the
// sequencer hands them out; latency, done pulse and final tables checked per sweep.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic row_ready;
  logic sel;

  always #5 clk = ~clk;

  truth_table_sequencer_if if1 ();
  truth_table_sequencer_if if3 ();

  assign if1.start     = start & ~sel;
  assign if3.start     = start & sel;
  assign if1.row_ready = row_ready;
  assign if3.row_ready = row_ready;

  truth_table_sequencer #(.STEP_DELAY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  truth_table_sequencer #(.STEP_DELAY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  logic       m_busy, m_rv, m_x, m_y, m_fa, m_fb, m_done;
  logic [3:0] m_ta, m_tb;

  assign m_busy = sel ? if3.busy      : if1.busy;
  assign m_rv   = sel ? if3.row_valid : if1.row_valid;
  assign m_x    = sel ? if3.row_x     : if1.row_x;
  assign m_y    = sel ? if3.row_y     : if1.row_y;
  assign m_fa   = sel ? if3.row_fa    : if1.row_fa;
  assign m_fb   = sel ? if3.row_fb    : if1.row_fb;
  assign m_done = sel ? if3.done      : if1.done;
  assign m_ta   = sel ? if3.table_a   : if1.table_a;
  assign m_tb   = sel ? if3.table_b   : if1.table_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the two gates, one row = {x, y, fa, fb}.
  function automatic logic [3:0] model_row(input logic [1:0] v);
    logic x, y;
    x = v[1];
    y = v[0];
    return {x, y, ~x & y, ~x | ~y};
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && m_rv && row_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_row", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("row", {28'd0, m_x, m_y, m_fa, m_fb}, {28'd0, e});
      end
    end
    if (m_done) n_done++;
  end

  // mode 0: plain, 1: stall on vector 01, 2: start during SETTLE of 10, 3: reset in HOLD of 10.
  // Entered and left just after a rising edge.
  task automatic run_sweep(input int mode, input int exp_lat);
    int   cyc;
    int   done0;
    logic done_seen;
    logic acted;
    for (int v = 0; v < 4; v++) exp_q.push_back(model_row(2'(v)));
    done0 = n_done;
    done_seen = 1'b0;
    acted = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", {31'd0, m_busy}, 32'd1);
    chk("tables_cleared", {24'd0, m_ta, m_tb}, 32'd0);
    while (cyc < 200 && !done_seen) begin
      if (mode == 1 && !acted && m_rv && !m_x && m_y) begin
        row_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          cyc++;
          chk("stall_valid", {31'd0, m_rv}, 32'd1);
          chk("stall_row", {28'd0, m_x, m_y, m_fa, m_fb}, 32'b0111);
        end
        row_ready = 1'b1;
        acted = 1'b1;
      end
      if (mode == 2 && !acted && m_busy && !m_rv && m_x && !m_y) begin
        start = 1'b1;
        acted = 1'b1;
      end
      if (mode == 3 && !acted && m_rv && m_x && !m_y) begin
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        chk("rst_valid", {31'd0, m_rv}, 32'd0);
        chk("rst_done", {31'd0, m_done}, 32'd0);
        chk("rst_rows", {30'd0, m_fa, m_fb}, 32'd0);
        chk("rst_tables", {24'd0, m_ta, m_tb}, 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", {31'd0, m_busy}, 32'd0);
        chk("rst_no_done", n_done - done0, 32'd0);
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (m_done) done_seen = 1'b1;
    end
    chk("done_seen", {31'd0, done_seen}, 32'd1);
    chk("latency", cyc, exp_lat);
    chk("table_a", {28'd0, m_ta}, 32'b0010);
    chk("table_b", {28'd0, m_tb}, 32'b0111);
    chk("rows_left", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    chk("done_width", {31'd0, m_done}, 32'd0);
    chk("done_count", n_done - done0, 32'd1);
    chk("idle_after", {31'd0, m_busy}, 32'd0);
    if (mode == 2) begin
      repeat (3) @(posedge clk);
      #1;
      chk("no_restart", {31'd0, m_busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    row_ready = 1'b1;
    sel       = 1'b0;
    #12;
    chk("reset_busy", {31'd0, m_busy}, 32'd0);
    chk("reset_valid", {31'd0, m_rv}, 32'd0);
    chk("reset_done", {31'd0, m_done}, 32'd0);
    chk("reset_xy_fa_fb", {28'd0, m_x, m_y, m_fa, m_fb}, 32'd0);
    chk("reset_tables", {24'd0, m_ta, m_tb}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", {31'd0, m_busy}, 32'd0);

    run_sweep(0, 9);
    run_sweep(0, 9);
    run_sweep(1, 14);
    run_sweep(2, 9);
    run_sweep(3, 0);
    run_sweep(0, 9);
    sel = 1'b1;
    @(posedge clk); #1;
    run_sweep(0, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
